mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Per-core load/store sequencer between a core's MEM stage and its word-only port on the 4-bank memory controller. One instance per core.
- Turns RISC-V byte, halfword and word loads/stores into 32-bit word accesses. Loads get sign/zero extension; sb/sh become a read-modify-write sequence.
- Uses a valid/ready request handshake and a one-cycle response pulse; detects misaligned accesses.

Parameters:
- PAGE_BYTES, 4096, size of the core's private page in bytes; word index = addr[log2(PAGE_BYTES)-1:2].
- ADDR_W, 32, width of the core-side and memory-side address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu. bu/hu are loads only.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal funct3; valid with resp_valid.
- mem_read_en  output  1  to controller coreN_mem_read_en.
- mem_write_en  output  1  to controller coreN_mem_write_en.
- mem_address  output  ADDR_W  to controller coreN_address; low 2 bits always 0.
- mem_write_data  output  32  to controller coreN_write_data.
- mem_read_data  input  32  from controller; combinational, valid in the same cycle as mem_read_en.

Behaviour:
- Reset (rst sampled high at a clock edge): state = IDLE.
  - req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0.
  - mem_read_en = 0; mem_write_en = 0; mem_address = 0; mem_write_data = 0.
  - Reset mid-sequence abandons the operation. No write is issued after reset; a pending RMW write is dropped.
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE: when req_valid && req_ready, latch write, funct3, addr, wdata.
  - Misaligned (h with addr[0] != 0; w with addr[1:0] != 0) or illegal funct3 (011, 110, 111, or store with bu/hu) -> RESP with err = 1. No memory port activity.
  - Otherwise -> ACCESS.
- ACCESS: mem_address = {addr[ADDR_W-1:2], 2'b00}.
  - Load: mem_read_en = 1. Select byte addr[1:0] or halfword addr[1]. Sign-extend for 000/001, zero-extend for 100/101, word as-is for 010. Capture into the response data register; -> RESP.
  - sw: mem_write_en = 1, mem_write_data = wdata; -> RESP.
  - sb/sh: mem_read_en = 1; latch mem_read_data into merge register; -> MERGE.
- MERGE: mem_write_en = 1, same mem_address. mem_write_data = latched word with the target lane replaced:
  - sb: byte lane addr[1:0] <- wdata[7:0].
  - sh: halfword lane addr[1] <- wdata[15:0].
  - -> RESP.
- RESP: resp_valid = 1 for exactly one cycle, with resp_rdata/resp_err; -> IDLE.
  - resp_rdata/resp_err hold until the next RESP; they are cleared to 0 on acceptance of the next request.
- mem_read_en and mem_write_en are never both high. Both are 0 in IDLE and RESP.
- Latency from the accept edge to the resp_valid cycle:
  - load / sw: 2 cycles.
  - sb / sh: 3 cycles.
  - error: 1 cycle.
- Throughput: one request per (latency + 1) cycles. req_ready is low from ACCESS through RESP.
- req_valid with req_ready low: no effect. The core holds the request until accepted.
- Address bits above the page index: passed through unchanged on mem_address (controller ignores them).

Optional Feature:
- Macro MAU_BOUNDS_CHECK_EN.
- Defined: addr >= PAGE_BYTES (any bit at or above log2(PAGE_BYTES) set) is treated as an error. Path IDLE -> RESP with resp_err = 1, no memory access. Alignment errors take the same path.
- Undefined: upper bits pass through and the access wraps within the page.

Test Plan:
- Reset, then sw addr 0x010 data 0xDEADBEEF -> cycle 1: mem_write_en=1, mem_address=0x010, mem_write_data=0xDEADBEEF; cycle 2: resp_valid=1, resp_err=0.
- After the above, lb 0x013 -> resp_rdata=0xFFFFFFDE. lbu 0x013 -> 0x000000DE. lh 0x010 -> 0xFFFFBEEF. lhu 0x012 -> 0x0000DEAD.
- sb 0x011 data 0x55 over 0xDEADBEEF -> ACCESS read then MERGE write 0xDEAD55EF; resp_valid 3 cycles after accept. Subsequent lw 0x010 returns 0xDEAD55EF.
- lw 0x002 and sh 0x001 -> resp_err=1 one cycle after accept; mem_read_en/mem_write_en stay 0 throughout.
- sh 0x020 accepted, rst asserted during ACCESS -> no mem_write_en pulse; next cycle all outputs 0 and req_ready=1; word 0x020 is unchanged.
- With MAU_BOUNDS_CHECK_EN: lw 0x1000 -> resp_err=1, no memory access. Without it: lw 0x1000 returns the data stored at 0x000.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Per-core load/store sequencer between a core MEM stage and a word-only
//   memory controller port. Byte/halfword loads are extracted and extended
//   from a 32-bit read; sb/sh become a read-modify-write (ACCESS read, MERGE
//   write). Misaligned or illegal requests answer with resp_err and never
//   touch the memory port.
//
//   Optional feature: define MAU_BOUNDS_CHECK_EN to reject any address at or
//   above PAGE_BYTES as an error. Undefined, upper bits pass through and the
//   controller wraps the access within the page.
//
//   Ports
//     clk, rst          system clock, synchronous active-high reset
//     req_*             core request (valid/ready), write, funct3, addr, wdata
//     resp_*            one-cycle completion pulse with rdata/err
//     mem_*             controller word port; mem_read_data is combinational
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   ACCESS | word read (load, sb/sh) or word write (sw)
//   MERGE  | write back the read word with the target lane replaced
//   RESP   | resp_valid pulse
module mem_access_unit #(
  parameter int PAGE_BYTES = 4096,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam int PAGE_LSB = $clog2(PAGE_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP} state_t;

  state_t      r_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata_lo;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_oob;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  // Request decode, evaluated on the incoming request in IDLE.
  always_comb begin
    w_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                 (req_funct3 == 3'b111) ||
                 (req_write && req_funct3[2]);
    // h and hu share funct3[1:0] == 01
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`ifdef MAU_BOUNDS_CHECK_EN
    w_oob      = |req_addr[ADDR_W-1:PAGE_LSB];
`else
    w_oob      = 1'b0;
`endif
    w_err      = w_illegal || w_misalign || w_oob;
  end

  // Lane extraction and extension of the word read in ACCESS.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = mem_read_data[7:0];
      2'd1:    w_byte = mem_read_data[15:8];
      2'd2:    w_byte = mem_read_data[23:16];
      default: w_byte = mem_read_data[31:24];
    endcase
    w_half = r_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_read_data;
    endcase
  end

  // Read word with the store lane replaced; registered into mem_write_data
  // at the end of ACCESS so MERGE drives a stable word.
  always_comb begin
    w_merge_data = mem_read_data;
    if (r_funct3[0]) begin
      if (r_lane[1]) w_merge_data[31:16] = r_wdata_lo;
      else           w_merge_data[15:0]  = r_wdata_lo;
    end else begin
      case (r_lane)
        2'd0:    w_merge_data[7:0]   = r_wdata_lo[7:0];
        2'd1:    w_merge_data[15:8]  = r_wdata_lo[7:0];
        2'd2:    w_merge_data[23:16] = r_wdata_lo[7:0];
        default: w_merge_data[31:24] = r_wdata_lo[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_write        <= 1'b0;
      r_funct3       <= 3'd0;
      r_lane         <= 2'd0;
      r_wdata_lo     <= 16'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'd0;
      resp_err       <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_funct3   <= req_funct3;
            r_lane     <= req_addr[1:0];
            r_wdata_lo <= req_wdata[15:0];
            req_ready  <= 1'b0;
            resp_rdata <= 32'd0;
            if (w_err) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              resp_err    <= 1'b0;
              mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_write && (req_funct3 == 3'b010)) begin
                mem_write_en   <= 1'b1;
                mem_write_data <= req_wdata;
              end else begin
                mem_read_en <= 1'b1;
              end
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          if (!r_write) begin
            resp_rdata <= w_load_data;
            resp_valid <= 1'b1;
            r_state    <= S_RESP;
          end else if (r_funct3 == 3'b010) begin
            resp_valid <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            mem_write_en   <= 1'b1;
            mem_write_data <= w_merge_data;
            r_state        <= S_MERGE;
          end
        end
        S_MERGE: begin
          mem_write_en <= 1'b0;
          resp_valid   <= 1'b1;
          r_state      <= S_RESP;
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int n_chk  = 0;
  int n_pass = 0;

  // event counters sampled on the falling edge
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int both_cnt = 0;
  logic [31:0] last_wr_data = 32'd0;
  logic [31:0] last_addr    = 32'd0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // controller model: ignores address bits above the page
  assign mem_read_data = mem[mem_address[11:2]];
  always @(posedge clk) if (mem_write_en) mem[mem_address[11:2]] <= mem_write_data;

  always @(negedge clk) begin
    if (mem_read_en) begin
      rd_cnt++;
      last_addr = mem_address;
    end
    if (mem_write_en) begin
      wr_cnt++;
      last_wr_data = mem_write_data;
      last_addr = mem_address;
    end
    if (mem_read_en && mem_write_en) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Issue one request; returns when resp_valid is seen (#1 after its edge).
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                        output logic err, output int rds, output int wrs);
    int rd0, wr0, w;
    w = 0;
    while (!req_ready && w < 10) begin
      @(posedge clk); #1; w++;
    end
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; rdata = 32'hx; err = 1'bx;
    for (int n = 1; n <= 10; n++) begin
      if (resp_valid) begin
        lat = n; rdata = resp_rdata; err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    rds = rd_cnt - rd0;
    wrs = wr_cnt - wr0;
  endtask

  task automatic run(input string tag, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int e_lat, input logic [31:0] e_rdata, input logic e_err,
                     input int e_rd, input int e_wr, input logic [31:0] e_wdata);
    int lat, rds, wrs;
    logic [31:0] rdata;
    logic err;
    do_req(wr, f3, addr, wd, lat, rdata, err, rds, wrs);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_rdata"}, rdata, e_rdata);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
    chk({tag, "_rd"}, rds, e_rd);
    chk({tag, "_wr"}, wrs, e_wr);
    if (e_wr > 0) begin
      chk({tag, "_wdata"}, last_wr_data, e_wdata);
      chk({tag, "_waddr"}, last_addr, {addr[31:2], 2'b00});
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outs", {29'd0, resp_valid, resp_err, mem_read_en | mem_write_en}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    rst = 1'b0;

    //   tag    wr  f3      addr          wdata          lat rdata          err rd wr wdata
    run("sw",   1, 3'b010, 32'h010, 32'hDEADBEEF, 2, 32'h0,        0, 0, 1, 32'hDEADBEEF);
    run("lb",   0, 3'b000, 32'h013, 32'h0,        2, 32'hFFFFFFDE, 0, 1, 0, 32'h0);
    run("lbu",  0, 3'b100, 32'h013, 32'h0,        2, 32'h000000DE, 0, 1, 0, 32'h0);
    run("lh",   0, 3'b001, 32'h010, 32'h0,        2, 32'hFFFFBEEF, 0, 1, 0, 32'h0);
    run("lhu",  0, 3'b101, 32'h012, 32'h0,        2, 32'h0000DEAD, 0, 1, 0, 32'h0);
    run("sb",   1, 3'b000, 32'h011, 32'h00000055, 3, 32'h0,        0, 1, 1, 32'hDEAD55EF);
    run("lw1",  0, 3'b010, 32'h010, 32'h0,        2, 32'hDEAD55EF, 0, 1, 0, 32'h0);
    run("lw_mis",0,3'b010, 32'h002, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0);
    run("sh_mis",1,3'b001, 32'h001, 32'h1234,     1, 32'h0,        1, 0, 0, 32'h0);
    run("sh",   1, 3'b001, 32'h012, 32'hFFFFABCD, 3, 32'h0,        0, 1, 1, 32'hABCD55EF);
    run("lw2",  0, 3'b010, 32'h010, 32'h0,        2, 32'hABCD55EF, 0, 1, 0, 32'h0);
    run("sbu",  1, 3'b100, 32'h010, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0);
    run("f011", 0, 3'b011, 32'h010, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0);
    run("lb0",  0, 3'b000, 32'h010, 32'h0,        2, 32'hFFFFFFEF, 0, 1, 0, 32'h0);

    // reset during ACCESS of an sh drops the pending merge write
    run("sw20", 1, 3'b010, 32'h020, 32'h12345678, 2, 32'h0,        0, 0, 1, 32'h12345678);
    begin
      int wr0, w;
      w = 0;
      while (!req_ready && w < 10) begin @(posedge clk); #1; w++; end
      wr0 = wr_cnt;
      req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h020; req_wdata = 32'h0000AAAA;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstmid_access_rd", {31'd0, mem_read_en}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
      chk("rstmid_outs", {29'd0, resp_valid, resp_err, mem_read_en | mem_write_en}, 32'd0);
      chk("rstmid_addr", mem_address, 32'd0);
      chk("rstmid_wdata", mem_write_data, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rstmid_nowr", wr_cnt - wr0, 0);
    end
    run("lw20", 0, 3'b010, 32'h020, 32'h0,        2, 32'h12345678, 0, 1, 0, 32'h0);

    // page wrap / bounds
    run("sw0",  1, 3'b010, 32'h000, 32'hCAFEF00D, 2, 32'h0,        0, 0, 1, 32'hCAFEF00D);
`ifdef MAU_BOUNDS_CHECK_EN
    run("lw1000",0,3'b010, 32'h1000, 32'h0,       1, 32'h0,        1, 0, 0, 32'h0);
`else
    run("lw1000",0,3'b010, 32'h1000, 32'h0,       2, 32'hCAFEF00D, 0, 1, 0, 32'h0);
    chk("wrap_addr", last_addr, 32'h1000);
`endif

    chk("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
